// File: rtl/adv7513_i2c_target.sv
// adv7513_i2c_target: I2C responder emulating a 256 x 8 register map, with a one-cycle
// strobe per accepted data byte and a registered fabric-side read port.
module adv7513_i2c_target #(
  parameter logic [6:0] CHIP_ADDR = 7'h72,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oen_o,
  output logic       busy_o,
  output logic       wr_strobe_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  input  logic [7:0] rd_addr_i,
  output logic [7:0] rd_data_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_P
  } state_e;

  state_e     state_q;
  logic [2:0] scl_q, sda_q;
  logic [2:0] bitcnt_q;
  logic [7:0] shift_q, ptr_q;
  logic       rw_q, sda_oen_q, busy_q, wr_strobe_q;
  logic [7:0] wr_addr_q, wr_data_q, rd_data_q;
  logic [7:0] map_q [256];

  logic       scl_rise_s, scl_fall_s, start_s, stop_s, sda_s;
  logic [7:0] byte_s;

  // Two-stage synchroniser plus one history stage for edge detection
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_s      = sda_q[1];
  assign scl_rise_s = scl_q[1] & ~scl_q[2];
  assign scl_fall_s = ~scl_q[1] & scl_q[2];
  assign start_s    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_s     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
  assign byte_s     = {shift_q[6:0], sda_s};

  // Protocol FSM; in ACK states sda_oen_q doubles as the "ACK already driven" phase bit
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      ptr_q       <= RESET_VAL;
      rw_q        <= 1'b0;
      sda_oen_q   <= 1'b1;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
      for (int i = 0; i < 256; i++) map_q[i] <= RESET_VAL;
    end else begin
      wr_strobe_q <= 1'b0;
      if (stop_s) begin
        state_q   <= IDLE;
        bitcnt_q  <= 3'd0;
        sda_oen_q <= 1'b1;
        busy_q    <= 1'b0;
      end else if (start_s) begin
        state_q   <= ADDR;
        bitcnt_q  <= 3'd0;
        sda_oen_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: sda_oen_q <= 1'b1;
          ADDR: if (scl_rise_s) begin
            shift_q  <= byte_s;
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              if (byte_s[7:1] == CHIP_ADDR) begin
                rw_q    <= byte_s[0];
                busy_q  <= 1'b1;
                state_q <= ADDR_ACK;
              end else begin
                busy_q  <= 1'b0;
                state_q <= WAIT_P;
              end
            end
          end
          ADDR_ACK: if (scl_fall_s) begin
            bitcnt_q <= 3'd0;
            if (sda_oen_q) begin
              sda_oen_q <= 1'b0;
            end else if (rw_q) begin
              shift_q   <= map_q[ptr_q];
              sda_oen_q <= map_q[ptr_q][7];
              state_q   <= RDATA;
            end else begin
              sda_oen_q <= 1'b1;
              state_q   <= REG;
            end
          end
          REG: if (scl_rise_s) begin
            shift_q  <= byte_s;
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              ptr_q   <= byte_s;
              state_q <= REG_ACK;
            end
          end
          REG_ACK, WDATA_ACK: if (scl_fall_s) begin
            bitcnt_q  <= 3'd0;
            sda_oen_q <= ~sda_oen_q;
            if (!sda_oen_q) state_q <= WDATA;
          end
          WDATA: if (scl_rise_s) begin
            shift_q  <= byte_s;
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              map_q[ptr_q] <= byte_s;
              wr_strobe_q  <= 1'b1;
              wr_addr_q    <= ptr_q;
              wr_data_q    <= byte_s;
              ptr_q        <= ptr_q + 8'd1;
              state_q      <= WDATA_ACK;
            end
          end
          RDATA: if (scl_fall_s) begin
            sda_oen_q <= shift_q[7];
          end else if (scl_rise_s) begin
            shift_q  <= {shift_q[6:0], 1'b1};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              ptr_q   <= ptr_q + 8'd1;
              state_q <= RDATA_ACK;
            end
          end
          RDATA_ACK: if (scl_fall_s) begin
            sda_oen_q <= 1'b1;
          end else if (scl_rise_s) begin
            bitcnt_q <= 3'd0;
            if (!sda_s) begin
              shift_q <= map_q[ptr_q];
              state_q <= RDATA;
            end else begin
              busy_q  <= 1'b0;
              state_q <= WAIT_P;
            end
          end
          WAIT_P: begin
            sda_oen_q <= 1'b1;
            busy_q    <= 1'b0;
          end
          default: begin
            state_q   <= IDLE;
            sda_oen_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Fabric read port; a same-cycle bus write to rd_addr_i returns the old value
  always_ff @(posedge clk_i) begin
    if (reset_i) rd_data_q <= 8'h00;
    else         rd_data_q <= map_q[rd_addr_i];
  end

  assign sda_oen_o   = sda_oen_q;
  assign busy_o      = busy_q;
  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign rd_data_o   = rd_data_q;

endmodule
